demux_1x16_collect: RTL and testbench

- Sequential 1-to-16 demultiplexer and serial-to-parallel collector. It is the write-side counterpart of the 16x1 bit-select mux.
- Routes single accepted input bits into slots of a 16-bit frame. The slot comes from the external select (addressed mode) or from an internal index counter (stream mode).
- Emits the assembled frame over a valid/ready handshake when all 16 slots are written or when a flush is requested.
- Sits between a serial bit source and any parallel consumer in the LC4 datapath test infrastructure.

---
 rtl/demux_1x16_collect_pkg.sv | 15 +
 rtl/demux_1x16_collect_if.sv | 28 ++
 rtl/demux_1x16_collect_dec.sv | 17 +
 rtl/demux_1x16_collect.sv | 95 +++++++++
 tb/tb_demux_1x16_collect.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/demux_1x16_collect_pkg.sv
// Shared definitions for the 1-to-16 demux / serial-to-parallel collector.
//   SEL_LENGTH / IN_LENGTH : select width and frame width (IN_LENGTH = 2**SEL_LENGTH)
//   state_e                : collector FSM states
//   ALL_ONES               : mask value of a completely written frame
package demux_pkg;
    localparam int SEL_LENGTH = 4;
    localparam int IN_LENGTH  = 1 << SEL_LENGTH;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    localparam logic [IN_LENGTH-1:0] ALL_ONES = '1;
endpackage

// File: rtl/demux_1x16_collect_if.sv
// Bit-in / frame-out bus of the collector.
//   master : bit source and frame consumer (drives in_*, sel, auto_mode, flush, out_ready)
//   slave  : the collector (drives in_ready, out_data, out_mask, out_valid)
interface demux_1x16_collect_if #(
    parameter int IN_LENGTH  = demux_pkg::IN_LENGTH,
    parameter int SEL_LENGTH = demux_pkg::SEL_LENGTH
);
    logic                  in_bit;
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_LENGTH-1:0] sel;
    logic                  auto_mode;
    logic                  flush;
    logic [IN_LENGTH-1:0]  out_data;
    logic [IN_LENGTH-1:0]  out_mask;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_bit, in_valid, sel, auto_mode, flush, out_ready,
        input  in_ready, out_data, out_mask, out_valid
    );

    modport slave (
        input  in_bit, in_valid, sel, auto_mode, flush, out_ready,
        output in_ready, out_data, out_mask, out_valid
    );
endinterface

// File: rtl/demux_1x16_collect_dec.sv
// Enable-gated binary-to-one-hot decoder producing per-slot write strobes.
//   en_i     : strobe enable (an accepted bit this cycle)
//   sel_i    : slot number
//   onehot_o : one bit set at sel_i when en_i, otherwise all zero
module demux_1x16_dec #(
    parameter int IN_LENGTH  = demux_pkg::IN_LENGTH,
    parameter int SEL_LENGTH = demux_pkg::SEL_LENGTH
) (
    input  logic                  en_i,
    input  logic [SEL_LENGTH-1:0] sel_i,
    output logic [IN_LENGTH-1:0]  onehot_o
);
    localparam logic [IN_LENGTH-1:0] ONE = IN_LENGTH'(1);

    // sel_i is only looked at when enabled, so an undriven select never leaks X.
    assign onehot_o = en_i ? (ONE << sel_i) : '0;
endmodule

// File: rtl/demux_1x16_collect.sv
// Sequential 1-to-16 demux and serial-to-parallel collector.
// Accepted bits land in a shadow frame at slot sel (addressed) or at an
// internal index (stream). A full mask or a flush of a non-empty frame
// publishes shadow+mask on out_data/out_mask with out_valid, held until
// out_ready.
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : slave side of demux_1x16_collect_if
module demux_1x16_collect
    import demux_pkg::*;
#(
    parameter int IN_LENGTH  = demux_pkg::IN_LENGTH,
    parameter int SEL_LENGTH = demux_pkg::SEL_LENGTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    demux_1x16_collect_if.slave   bus
);
    localparam logic [IN_LENGTH-1:0] MASK_FULL = '1;

    state_e                state_q;
    logic [IN_LENGTH-1:0]  shadow_q, mask_q;
    logic [SEL_LENGTH-1:0] idx_q;
    logic [IN_LENGTH-1:0]  out_data_q, out_mask_q;
    logic                  out_valid_q;

    logic                  accept;
    logic [SEL_LENGTH-1:0] slot;
    logic [IN_LENGTH-1:0]  wr;
    logic [IN_LENGTH-1:0]  shadow_d, mask_d;
    logic                  emit;

    // Held low during reset so nothing is taken while state is being cleared.
    assign bus.in_ready = (state_q == COLLECT) && rstn;
    assign accept       = bus.in_valid && bus.in_ready;
    assign slot         = bus.auto_mode ? idx_q : bus.sel;

    demux_1x16_dec #(
        .IN_LENGTH  (IN_LENGTH),
        .SEL_LENGTH (SEL_LENGTH)
    ) u_dec (
        .en_i     (accept),
        .sel_i    (slot),
        .onehot_o (wr)
    );

    // Post-write view of the frame: the current bit is already included, so a
    // flush in the same cycle as an accept emits that bit too.
    assign shadow_d = (shadow_q & ~wr) | (wr & {IN_LENGTH{bus.in_bit}});
    assign mask_d   = mask_q | wr;
    assign emit     = (mask_d == MASK_FULL) || (bus.flush && (mask_d != '0));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= COLLECT;
            shadow_q    <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (emit) begin
                        out_data_q  <= shadow_d;
                        out_mask_q  <= mask_d;
                        out_valid_q <= 1'b1;
                        shadow_q    <= '0;
                        mask_q      <= '0;
                        idx_q       <= '0;
                        state_q     <= FULL;
                    end else if (accept) begin
                        shadow_q <= shadow_d;
                        mask_q   <= mask_d;
                        if (bus.auto_mode)
                            idx_q <= SEL_LENGTH'(idx_q + 1'b1);
                    end
                end
                FULL: begin
                    // out_data/out_mask keep their value after the handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_demux_1x16_collect.sv
module tb_demux_1x16_collect;
    import demux_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    demux_1x16_collect_if bus ();

    demux_1x16_collect dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one bit for one clock edge; returns on the following negedge.
    task automatic put(input logic b, input logic [3:0] s, input logic am, input logic fl);
        bus.in_bit    = b;
        bus.sel       = s;
        bus.auto_mode = am;
        bus.flush     = fl;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    logic [15:0] w;
    logic [15:0] held_d, held_m;

    initial begin
        checks = 0;
        errors = 0;
        rstn          = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel       = 4'd0;
        bus.auto_mode = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        idle(); idle();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_valid",    32'(bus.out_valid), 32'd0);
        chk("rst_data",     32'(bus.out_data), 32'h0);
        chk("rst_mask",     32'(bus.out_mask), 32'h0);
        rstn = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        idle();

        // Stream fill: slot 0 first, expected frame 8F0D
        w = 16'h8F0D;
        for (int i = 0; i < 15; i++) put(w[i], 4'd0, 1'b1, 1'b0);
        chk("stream_no_early_valid", 32'(bus.out_valid), 32'd0);
        put(w[15], 4'd0, 1'b1, 1'b0);
        chk("stream_valid",    32'(bus.out_valid), 32'd1);
        chk("stream_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stream_data",     32'(bus.out_data), 32'h8F0D);
        chk("stream_mask",     32'(bus.out_mask), 32'(ALL_ONES));
        idle();
        chk("stream_drop_valid", 32'(bus.out_valid), 32'd0);
        chk("stream_back_ready", 32'(bus.in_ready), 32'd1);
        chk("stream_data_hold",  32'(bus.out_data), 32'h8F0D);

        // Addressed with overwrite, then flush
        put(1'b1, 4'd3,  1'b0, 1'b0);
        put(1'b0, 4'd3,  1'b0, 1'b0);
        put(1'b1, 4'd15, 1'b0, 1'b0);
        chk("addr_no_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
        chk("addr_valid", 32'(bus.out_valid), 32'd1);
        chk("addr_data",  32'(bus.out_data), 32'h8000);
        chk("addr_mask",  32'(bus.out_mask), 32'h8008);
        idle();

        // Flush together with an accept
        put(1'b1, 4'd5, 1'b0, 1'b1);
        chk("flacc_valid", 32'(bus.out_valid), 32'd1);
        chk("flacc_data",  32'(bus.out_data), 32'h0020);
        chk("flacc_mask",  32'(bus.out_mask), 32'h0020);
        idle();

        // Flush on an empty frame is ignored
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
        chk("empty_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_flush_ready", 32'(bus.in_ready), 32'd1);
        idle();
        chk("empty_flush_valid2", 32'(bus.out_valid), 32'd0);

        // Back-pressure
        bus.out_ready = 1'b0;
        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) put(w[i], 4'd0, 1'b1, 1'b0);
        held_d = 16'hA5C3;
        held_m = 16'hFFFF;
        bus.in_bit    = 1'b1;
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_data",     32'(bus.out_data), 32'(held_d));
            chk("bp_mask",     32'(bus.out_mask), 32'(held_m));
            idle();
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        put(1'b1, 4'd9, 1'b1, 1'b1);
        chk("bp_next_slot0_data", 32'(bus.out_data), 32'h0001);
        chk("bp_next_slot0_mask", 32'(bus.out_mask), 32'h0001);
        idle();

        // Reset mid-frame
        for (int i = 0; i < 7; i++) put(1'b1, 4'd0, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        chk("midrst_in_ready_low", 32'(bus.in_ready), 32'd0);
        idle();
        rstn = 1'b1;
        #1;
        chk("midrst_data",     32'(bus.out_data), 32'h0);
        chk("midrst_mask",     32'(bus.out_mask), 32'h0);
        chk("midrst_valid",    32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        idle();
        w = 16'h1234;
        for (int i = 0; i < 15; i++) put(w[i], 4'd0, 1'b1, 1'b0);
        chk("midrst_no_early_valid", 32'(bus.out_valid), 32'd0);
        put(w[15], 4'd0, 1'b1, 1'b0);
        chk("midrst_frame_valid", 32'(bus.out_valid), 32'd1);
        chk("midrst_frame_data",  32'(bus.out_data), 32'h1234);
        chk("midrst_frame_mask",  32'(bus.out_mask), 32'hFFFF);
        idle();

        // Mode switch mid-frame
        for (int i = 0; i < 4; i++) put(1'b1, 4'd0, 1'b1, 1'b0);
        put(1'b1, 4'd10, 1'b0, 1'b0);
        put(1'b1, 4'd0,  1'b1, 1'b0);
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
        chk("mode_valid", 32'(bus.out_valid), 32'd1);
        chk("mode_data",  32'(bus.out_data), 32'h041F);
        chk("mode_mask",  32'(bus.out_mask), 32'h041F);
        idle();
        chk("mode_release", 32'(bus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
